// File: rtl/i2c_tx_shifter_if.sv
// Bus bundle between the I2C bus controller (master) and the byte transmit shifter (slave).
interface i2c_tx_shifter_if #(
  parameter int unsigned data_width = 8
) ();

  // Controller -> shifter
  logic                  load;
  logic [data_width-1:0] data_in;
  logic                  abort;
  logic                  scl_fall;
  logic                  scl_rise;
  logic                  sda_in;

  // Shifter -> controller
  logic                  sda_out;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  ack_rcvd;

  modport master (
    output load,
    output data_in,
    output abort,
    output scl_fall,
    output scl_rise,
    output sda_in,
    input  sda_out,
    input  ready,
    input  busy,
    input  done,
    input  ack_rcvd
  );

  modport slave (
    input  load,
    input  data_in,
    input  abort,
    input  scl_fall,
    input  scl_rise,
    input  sda_in,
    output sda_out,
    output ready,
    output busy,
    output done,
    output ack_rcvd
  );

endinterface

// File: rtl/i2c_tx_shifter.sv
// I2C parallel-in / serial-out byte transmitter. Drives one data bit per SCL low phase,
// releases SDA for the ninth clock and samples the receiver's ACK/NACK on that SCL rise.
// All outputs are registered; next-state values for every output are computed in one
// combinational process from the next FSM state.
module i2c_tx_shifter #(
  parameter int unsigned data_width = 8,
  parameter bit          msb_first  = 1'b1
) (
  input logic             clk,
  input logic             rst_,
  i2c_tx_shifter_if.slave bus
);

  localparam int unsigned CntW = $clog2(data_width);
  localparam logic [CntW-1:0] LastBit = CntW'(data_width - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StAck,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  rise_seen_q, rise_seen_d;  // ninth SCL rise already sampled
  logic                  ack_rcvd_q, ack_rcvd_d;
  logic                  sda_out_q, sda_out_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  rise_eff;

  // Bit currently presented on SDA: the end of the register nearest the shift direction.
  function automatic logic head_bit(input logic [data_width-1:0] v);
    return msb_first ? v[data_width-1] : v[0];
  endfunction

  // Move the register one position toward its head, zero filling the vacated end.
  function automatic logic [data_width-1:0] shift_once(input logic [data_width-1:0] v);
    return msb_first ? {v[data_width-2:0], 1'b0} : {1'b0, v[data_width-1:1]};
  endfunction

  // A simultaneous rise and fall is illegal; the fall is honoured and the rise dropped.
  assign rise_eff = bus.scl_rise & ~bus.scl_fall;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rise_seen_d = rise_seen_q;
    ack_rcvd_d  = ack_rcvd_q;

    if (bus.abort) begin
      state_d     = StIdle;
      rise_seen_d = 1'b0;
      ack_rcvd_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.load) begin
            shift_d     = bus.data_in;
            bit_cnt_d   = '0;
            ack_rcvd_d  = 1'b0;
            rise_seen_d = 1'b0;
            state_d     = StData;
          end
        end
        StData: begin
          // SCL rise needs no action here: the bit is simply held through SCL high.
          if (bus.scl_fall) begin
            if (bit_cnt_q == LastBit) begin
              rise_seen_d = 1'b0;
              state_d     = StAck;
            end else begin
              shift_d   = shift_once(shift_q);
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
        StAck: begin
          // A fall before the ninth rise belongs to the previous bit's tail and is ignored.
          if (bus.scl_fall && rise_seen_q) begin
            state_d = StDone;
          end else if (rise_eff && !rise_seen_q) begin
            ack_rcvd_d  = ~bus.sda_in;
            rise_seen_d = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    sda_out_d = (state_d == StData) ? head_bit(shift_d) : 1'b1;
    ready_d   = (state_d == StIdle);
    busy_d    = (state_d == StData) || (state_d == StAck);
    done_d    = (state_d == StDone);
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rise_seen_q <= 1'b0;
      ack_rcvd_q  <= 1'b0;
      sda_out_q   <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rise_seen_q <= rise_seen_d;
      ack_rcvd_q  <= ack_rcvd_d;
      sda_out_q   <= sda_out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.sda_out  = sda_out_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ack_rcvd = ack_rcvd_q;

endmodule

// File: doc/i2c_tx_shifter.md
Name: i2c_tx_shifter

Overview:
Parallel-in, serial-out byte transmitter for the I2C datapath; the transmit-side counterpart of the serial-in capture shift register. It accepts a parallel word, drives it onto SDA one bit per SCL low phase, then releases SDA and samples the receiver's ACK/NACK on the ninth clock. SCL edge detection and START/STOP generation live in the bus controller, which supplies single-cycle SCL edge strobes.

Parameters:
data_width, 8, number of data bits per transfer (legal range 2..16)
msb_first, 1, 1 = transmit data_in[data_width-1] first; 0 = transmit data_in[0] first

Ports:
clk  input  1  system clock, rising edge
rst_  input  1  asynchronous active-low reset
load  input  1  start a transfer; accepted only while ready=1
data_in  input  data_width  word to transmit, captured on the accepted load
abort  input  1  synchronous cancel; highest priority after reset
scl_fall  input  1  one-clk strobe on each SCL high->low transition
scl_rise  input  1  one-clk strobe on each SCL low->high transition
sda_in  input  1  synchronized SDA line level
sda_out  output  1  SDA drive value, open-drain: 0 = pull low, 1 = release
ready  output  1  idle and able to accept load
busy  output  1  transfer in progress (DATA or ACK state)
done  output  1  one-clk pulse when a transfer completes
ack_rcvd  output  1  1 = receiver ACKed (SDA low at ninth SCL rise); held until next accepted load

Behaviour:
- Reset (async, rst_=0): state IDLE; sda_out=1, ready=1, busy=0, done=0, ack_rcvd=0, shift reg=0, bit_cnt=0.
- States: IDLE, DATA, ACK, DONE. All outputs are registered.
- IDLE: ready=1, sda_out=1. On load=1: capture data_in into the shift reg, clear bit_cnt and ack_rcvd, go to DATA. The first bit appears on sda_out one clk after load. The controller issues load only while SCL is low.
- DATA: sda_out = current head bit (MSB of the shift reg if msb_first=1, else LSB).
- DATA, each scl_fall: shift the reg one position (zero fill) toward the head; bit_cnt+1.
- DATA, scl_fall with bit_cnt = data_width-1: go to ACK instead of shifting further. sda_out=1 in the next clk.
- scl_rise in DATA: no state change. The data bit must be stable through SCL high.
- ACK: sda_out=1 (released).
- ACK, first scl_rise: ack_rcvd <= ~sda_in.
- ACK, following scl_fall: go to DONE.
- An scl_fall in ACK before any scl_rise is ignored.
- DONE: done=1 for exactly one clk, ready=0. Next clk: IDLE, ready=1.
- busy=1 exactly in DATA and ACK.
- load while ready=0 is ignored, with no effect on the shift reg or ack_rcvd.
- abort=1 in any state: next clk IDLE, sda_out=1, no done pulse, ack_rcvd=0. abort beats a simultaneous load.
- scl_rise and scl_fall asserted in the same clk is illegal. Design response: scl_fall wins and scl_rise is dropped.
- Reset mid-transfer: SDA is released immediately (asynchronous) and the block returns to IDLE.
- Latency: a load-to-done transfer spans data_width+1 scl_fall strobes plus 2 clks.

Test Plan:
1. msb_first=1, load data_in=8'hA5, then 9 SCL periods with sda_in=0 at the 9th rise -> sda_out sequence 1,0,1,0,0,1,0,1 sampled at each scl_rise. Then sda_out=1 during ACK, ack_rcvd=1, one done pulse, ready=1 one clk later.
2. load 8'h3C with sda_in=1 at the 9th rise -> bits 0,0,1,1,1,1,0,0 transmitted; ack_rcvd=0 (NACK); done pulses once.
3. msb_first=0, load 8'h01 -> first transmitted bit 1, remaining 7 bits 0.
4. Assert abort after the 3rd scl_fall of 8'hFF -> sda_out=1 next clk, state IDLE, done never asserted, ack_rcvd=0, ready=1.
5. Second load (8'h00) pulsed while busy during an 8'hFF transfer -> ignored; all 8 bits transmit as 1.
6. rst_ low mid-DATA while sda_out=0 -> sda_out=1 and ready=1 without waiting for a clk edge; after release a fresh load of 8'h81 transmits correctly.
